// File: rtl/eq_pkg.sv
// Shared constants and FSM encoding for the equalizer band mixer and its
// downstream stages.
package eq_pkg;

  localparam int unsigned DATA_BIT_NUM = 16;
  localparam int unsigned GAIN_BIT_NUM = 16;
  localparam int unsigned GAIN_FRAC    = 12;
  localparam int unsigned BAND_NUM     = 5;
  localparam int unsigned ADDR_BIT_NUM = 3;
  // Three guard bits cover the sum of BAND_NUM full-scale products.
  localparam int unsigned ACC_BIT_NUM  = DATA_BIT_NUM + GAIN_BIT_NUM + 3;

  localparam logic [GAIN_BIT_NUM-1:0] UNITY_GAIN = 16'h1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up and saturate from a wide fixed-point accumulator
// down to a signed output word, with a clip indication.
module eq_round_sat
  import eq_pkg::*;
#(
  parameter int unsigned AccW = ACC_BIT_NUM,
  parameter int unsigned OutW = DATA_BIT_NUM,
  parameter int unsigned Frac = GAIN_FRAC
) (
  input  logic signed [AccW-1:0] acc_i,
  output logic signed [OutW-1:0] result_o,
  output logic                   sat_o
);

  localparam int unsigned ScW = AccW + 1 - Frac;

  localparam logic signed [AccW:0] Half =
    {{(AccW - Frac + 1){1'b0}}, 1'b1, {(Frac - 1){1'b0}}};
  localparam logic signed [ScW-1:0] MaxVal = {{(ScW - OutW + 1){1'b0}}, {(OutW - 1){1'b1}}};
  localparam logic signed [ScW-1:0] MinVal = {{(ScW - OutW + 1){1'b1}}, {(OutW - 1){1'b0}}};

  logic signed [AccW:0]   biased;
  logic signed [ScW-1:0]  scaled;
  logic                   unused_frac;

  // One extra bit so adding the half-LSB can never wrap.
  assign biased      = {acc_i[AccW-1], acc_i} + Half;
  assign scaled      = biased[AccW:Frac];
  assign unused_frac = ^biased[Frac-1:0];

  always_comb begin
    result_o = scaled[OutW-1:0];
    sat_o    = 1'b0;
    if (scaled > MaxVal) begin
      result_o = MaxVal[OutW-1:0];
      sat_o    = 1'b1;
    end else if (scaled < MinVal) begin
      result_o = MinVal[OutW-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Mixes one set of band-filter samples into a single equalized sample using
// per-band Q4.12 gains and a single shared multiplier.
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int unsigned DATA_BIT_NUM = eq_pkg::DATA_BIT_NUM,
  parameter int unsigned BAND_NUM     = eq_pkg::BAND_NUM,
  parameter int unsigned GAIN_BIT_NUM = eq_pkg::GAIN_BIT_NUM,
  parameter int unsigned GAIN_FRAC    = eq_pkg::GAIN_FRAC,
  parameter int unsigned ADDR_BIT_NUM = eq_pkg::ADDR_BIT_NUM
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [BAND_NUM*DATA_BIT_NUM-1:0] band_data,
  output logic                             in_ready,
  input  logic                             gain_wr_en,
  input  logic [ADDR_BIT_NUM-1:0]          gain_wr_addr,
  input  logic [GAIN_BIT_NUM-1:0]          gain_wr_data,
  output logic [DATA_BIT_NUM-1:0]          data_out,
  output logic                             out_valid,
  output logic                             sat_flag,
  output logic                             overrun
);

  localparam int unsigned AccBits  = DATA_BIT_NUM + GAIN_BIT_NUM + 3;
  localparam int unsigned ProdBits = DATA_BIT_NUM + GAIN_BIT_NUM;
  localparam logic [ADDR_BIT_NUM-1:0] LastIdx = ADDR_BIT_NUM'(BAND_NUM - 1);

  state_e state_q, state_d;

  logic signed [AccBits-1:0]      acc_q, acc_d;
  logic [ADDR_BIT_NUM-1:0]        idx_q, idx_d;
  logic signed [DATA_BIT_NUM-1:0] band_q [BAND_NUM];
  logic signed [DATA_BIT_NUM-1:0] band_d [BAND_NUM];
  logic signed [GAIN_BIT_NUM-1:0] gain_q [BAND_NUM];

  logic [DATA_BIT_NUM-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;
  logic                    overrun_q, overrun_d;

  logic signed [ProdBits-1:0]     prod;
  logic signed [DATA_BIT_NUM-1:0] rs_result;
  logic                           rs_sat;

  assign prod = band_q[idx_q] * gain_q[idx_q];

  eq_round_sat #(
    .AccW(AccBits),
    .OutW(DATA_BIT_NUM),
    .Frac(GAIN_FRAC)
  ) u_round_sat (
    .acc_i    (acc_q),
    .result_o (rs_result),
    .sat_o    (rs_sat)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    band_d    = band_q;
    data_d    = data_q;
    sat_d     = sat_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (in_valid & (state_q != StIdle));
    in_ready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int k = 0; k < int'(BAND_NUM); k++) begin
            band_d[k] = band_data[k*DATA_BIT_NUM +: DATA_BIT_NUM];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + AccBits'(prod);
        idx_d = idx_q + ADDR_BIT_NUM'(1);
        if (idx_q == LastIdx) begin
          state_d = StOut;
        end
      end
      StOut: begin
        data_d  = rs_result;
        sat_d   = rs_sat;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < int'(BAND_NUM); k++) begin
        band_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
      band_q    <= band_d;
    end
  end

  // Writes to out-of-range addresses match no band and are dropped.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(BAND_NUM); k++) begin
      if (!rst) begin
        gain_q[k] <= UNITY_GAIN;
      end else if (gain_wr_en && (gain_wr_addr == ADDR_BIT_NUM'(k))) begin
        gain_q[k] <= gain_wr_data;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign sat_flag  = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer: directed sample sets push expected
// results; a negedge monitor pops and compares on every out_valid.
module tb_eq_band_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [79:0] band_data = '0;
  logic        in_ready;
  logic        gain_wr_en = 1'b0;
  logic [2:0]  gain_wr_addr = '0;
  logic [15:0] gain_wr_data = '0;
  logic [15:0] data_out;
  logic        out_valid;
  logic        sat_flag;
  logic        overrun;

  eq_band_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .band_data    (band_data),
    .in_ready     (in_ready),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_addr (gain_wr_addr),
    .gain_wr_data (gain_wr_data),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .sat_flag     (sat_flag),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected out_valid: got data %0h at cycle %0d, required none",
                 data_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", {16'h0, data_out}, {16'h0, mon_e.data});
        check("sat_flag", {31'h0, sat_flag}, {31'h0, mon_e.sat});
        check("latency", cyc, mon_e.when);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wgain(input logic [2:0] addr, input logic [15:0] val);
    @(negedge clk);
    gain_wr_en   = 1'b1;
    gain_wr_addr = addr;
    gain_wr_data = val;
    @(negedge clk);
    gain_wr_en   = 1'b0;
  endtask

  // Accept edge is the next posedge; out_valid is seen at the negedge after
  // the sixth edge following it.
  task automatic send(input int b0, input int b1, input int b2, input int b3, input int b4,
                      input int ed, input bit es, input bit expect_out);
    exp_t e;
    @(negedge clk);
    band_data = {b4[15:0], b3[15:0], b2[15:0], b1[15:0], b0[15:0]};
    in_valid  = 1'b1;
    if (expect_out) begin
      e.data = ed[15:0];
      e.sat  = es;
      e.when = cyc + 7;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int v, input int ed, input bit es);
    send(v, v, v, v, v, ed, es, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL timeout: %0d results missing, required 0", sb.size());
      sb.delete();
    end
    idle(3);
  endtask

  initial begin
    rst = 1'b0;
    idle(3);
    check("reset data_out", {16'h0, data_out}, 32'h0);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset sat_flag", {31'h0, sat_flag}, 32'h0);
    check("reset overrun", {31'h0, overrun}, 32'h0);
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b1;
    idle(2);

    // Unity gains after reset.
    send_all(1000, 5000, 1'b0);
    check("in_ready busy", {31'h0, in_ready}, 32'h0);
    drain();

    wgain(3'd0, 16'h2000);
    for (int k = 1; k < 5; k++) wgain(3'(k), 16'h0000);
    send(-1200, 7, 7, 7, 7, -2400, 1'b0, 1'b1);
    drain();

    // Half gain on band 0 exercises round-half-up.
    wgain(3'd0, 16'h0800);
    send(3, 0, 0, 0, 0, 2, 1'b0, 1'b1);
    drain();
    send(-3, 0, 0, 0, 0, -1, 1'b0, 1'b1);
    drain();
    send(4, 0, 0, 0, 0, 2, 1'b0, 1'b1);
    drain();

    for (int k = 0; k < 5; k++) wgain(3'(k), 16'h1000);
    send_all(30000, 32767, 1'b1);
    drain();
    send_all(-32768, -32768, 1'b1);
    drain();
    check("hold data_out", {16'h0, data_out}, 32'h0000_8000);
    check("hold sat_flag", {31'h0, sat_flag}, 32'h1);

    // Second pulse two edges after accept must be dropped.
    check("overrun before", {31'h0, overrun}, 32'h0);
    send_all(100, 500, 1'b0);
    @(negedge clk);
    band_data = {5{16'd200}};
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    check("overrun set", {31'h0, overrun}, 32'h1);
    drain();
    idle(10);
    check("overrun sticky", {31'h0, overrun}, 32'h1);

    wgain(3'd6, 16'h0000);
    send_all(1000, 5000, 1'b0);
    drain();

    // Reset mid-MAC: no output, gains restored, overrun cleared.
    wgain(3'd2, 16'h0000);
    send(1000, 1000, 1000, 1000, 1000, 0, 1'b0, 1'b0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(10);
    check("overrun after reset", {31'h0, overrun}, 32'h0);
    check("data_out after reset", {16'h0, data_out}, 32'h0);
    check("in_ready after reset", {31'h0, in_ready}, 32'h1);
    send_all(10, 50, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
Downstream stage of the parallel iir_filter_5tabs band filters in the equalizer. Each output sample is formed from the 5 band samples produced for the same input sample. The block multiplies each band by a programmable gain (Q4.12), accumulates the products sequentially through one shared multiplier, then rounds, saturates and emits one 16-bit equalized sample with a valid strobe.

Parameters:
DATA_BIT_NUM, 16, width of band samples and data_out (signed two's complement)
BAND_NUM, 5, number of bands mixed
GAIN_BIT_NUM, 16, signed gain width, Q4.12 format
GAIN_FRAC, 12, fractional bits of gain
ADDR_BIT_NUM, 3, gain address width (ceil(log2(BAND_NUM)))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
in_valid  in  1  band_data holds a new set of band samples
band_data  in  BAND_NUM*DATA_BIT_NUM  band k in bits [k*16 +: 16], signed
in_ready  out  1  block can accept a new sample set
gain_wr_en  in  1  gain register write strobe
gain_wr_addr  in  ADDR_BIT_NUM  band index written
gain_wr_data  in  GAIN_BIT_NUM  signed Q4.12 gain value
data_out  out  DATA_BIT_NUM  mixed, rounded, saturated sample
out_valid  out  1  one-cycle strobe, data_out is new
sat_flag  out  1  data_out was clipped; valid with out_valid
overrun  out  1  sticky: in_valid arrived while in_ready = 0

Behaviour:
- Reset (rst = 0 at an edge): FSM to IDLE; accumulator and band index cleared; data_out = 0, out_valid = 0, sat_flag = 0, overrun = 0; all gains = 0x1000 (unity). Reset wins over every other event at the same edge.
- FSM states IDLE, MAC, OUT.
- IDLE: in_ready = 1. At an edge with in_valid = 1, band_data is latched, acc = 0, idx = 0, next state MAC.
- MAC: in_ready = 0. Each edge: acc += band[idx] * gain[idx]; idx++. After BAND_NUM edges, next state OUT.
- OUT: in_ready = 0. Round: (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (arithmetic shift, round half up). Saturate to [-32768, 32767] and set sat_flag if clipped. data_out and sat_flag are registered and out_valid = 1 for one cycle. Next state IDLE.
- Latency: if accept is at edge 0, out_valid is high in the cycle after edge BAND_NUM+1. Minimum spacing between accepts is BAND_NUM+2 cycles.
- data_out and sat_flag hold their values between strobes. out_valid is 0 except for the single strobe cycle.
- Accumulator width is DATA_BIT_NUM + GAIN_BIT_NUM + 3 (35 bits). Products are full signed. No intermediate overflow is possible.
- in_valid while in_ready = 0: the sample set is dropped and overrun is set to 1. overrun stays 1 until reset.
- Gain writes are honoured in any state and take effect at the write edge. If a write to band k lands on the same edge that MAC uses band k, MAC uses the old value.
- gain_wr_addr >= BAND_NUM: the write is ignored.
- Reset during MAC or OUT: the partial result is discarded and no out_valid is produced.

Decomposition:
- Package eq_pkg holds DATA_BIT_NUM, GAIN_BIT_NUM, GAIN_FRAC, BAND_NUM, the derived ACC_BIT_NUM, the unity-gain constant 0x1000, and the FSM state encoding (IDLE = 0, MAC = 1, OUT = 2).
- One sub-module is natural: eq_round_sat. It is combinational and maps the accumulator to a 16-bit result plus a saturation bit, and is reused by later equalizer stages.

Test Plan:
- Gains at reset, all bands = 1000, in_valid pulse -> out_valid exactly 7 cycles after the accept edge, data_out = 5000, sat_flag = 0.
- Write gain0 = 0x2000 and gains 1..4 = 0; band0 = -1200, others = 7 -> data_out = -2400.
- Unity gains, all bands = 30000 -> data_out = 32767, sat_flag = 1. All bands = -32768 -> data_out = -32768, sat_flag = 1.
- Rounding: gain0 = 0x0800, other gains = 0. band0 = 3 -> 2; band0 = -3 -> -1; band0 = 4 -> 2.
- Second in_valid pulse 2 cycles after an accept -> overrun = 1 and stays 1. Only one out_valid, carrying the first sample's result. Write to gain_wr_addr = 6 -> no gain changes.
- Deassert rst during MAC (cycle 3) -> no out_valid, gains back to 0x1000, overrun = 0. The next sample (all bands = 10) gives 50.
